// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the byte-lane helper used by the SRAM slave.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_t;

  localparam int unsigned CNT_W = 4;

  // Bit n is set when byte offset n within the bus word is covered by the transfer.
  function automatic logic [7:0] lane_mask(input logic [2:0] addr_lo,
                                           input logic [2:0] size,
                                           input int dw);
    logic [7:0] m;
    int off;
    int n;
    m   = '0;
    off = int'(addr_lo) & (dw / 8 - 1);
    n   = 1 << size;
    for (int b = 0; b < 8; b++) begin
      if (b >= off && b < off + n) m[b] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/ahb_lite_resp_fsm.sv
// Response sequencer: wait-state down-counter and the two-cycle ERROR response.
//   state    | meaning
//   ST_IDLE  | no stall; completes a zero-wait data phase when pend is set
//   ST_WAIT  | inserting wait states, cnt = cycles left
//   ST_ERR1  | first ERROR cycle, hreadyout low
//   ST_ERR2  | second ERROR cycle, hreadyout high, may accept a new transfer
module ahb_lite_resp_fsm
  import ahb_lite_pkg::*;
(
  input  logic             hclk,
  input  logic             hresetn,
  input  logic             accept,
  input  logic             err,
  input  logic [CNT_W-1:0] wait_len,
  output logic             take,
  output logic             hreadyout,
  output logic             hresp,
  output logic             dp_done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR1 = 2'd2;
  localparam logic [1:0] ST_ERR2 = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             pend;

  assign take = accept && (state == ST_IDLE || state == ST_ERR2);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      pend  <= 1'b0;
    end else begin
      pend <= 1'b0;
      case (state)
        ST_WAIT: begin
          if (cnt <= 4'd1) begin
            state <= ST_IDLE;
            pend  <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_ERR1: state <= ST_ERR2;
        default: begin
          state <= ST_IDLE;
          if (take) begin
            if (err) begin
              state <= ST_ERR1;
            end else if (wait_len != '0) begin
              state <= ST_WAIT;
              cnt   <= wait_len;
            end else begin
              pend <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign hreadyout = (state != ST_WAIT) && (state != ST_ERR1);
  assign hresp     = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign dp_done   = pend;

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: address-phase capture, protocol error detection, byte-lane memory.
module ahb_lite_sram_slave
  import ahb_lite_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned MEM_BYTES  = 4096,
  parameter int unsigned BIG_ENDIAN = 0,
  parameter int unsigned LW_NS      = 0,
  parameter int unsigned LW_S       = 0,
  parameter int unsigned LR_NS      = 1,
  parameter int unsigned LR_S       = 0,
  parameter int unsigned ERR_BASE   = 'hF00,
  parameter int unsigned ERR_SIZE   = 0,
  parameter logic [7:0]  INIT_VAL   = 8'h00
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic          hsel,
  input  logic [AW-1:0] haddr,
  input  logic [1:0]    htrans,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic [2:0]    hburst,
  input  logic [3:0]    hprot,
  input  logic [DW-1:0] hwdata,
  input  logic          hready,
  output logic          hreadyout,
  output logic          hresp,
  output logic [DW-1:0] hrdata,
  input  logic          err_inj
);

  localparam int NB = DW / 8;
  localparam int LB = $clog2(NB);
  localparam int MA = $clog2(MEM_BYTES);

  logic             accept, take, dp_done;
  logic             err_now, misalign, oversize, in_win;
  logic [6:0]       size_mask;
  logic [31:0]      off32;
  logic [CNT_W-1:0] wait_len;

  logic [MA-1:0]    dp_addr;
  logic             dp_write, dp_err;
  logic [2:0]       dp_size;

  logic [7:0]       mask_le;
  logic [2:0]       lane_off  [NB];
  logic [MA-1:0]    lane_addr [NB];
  logic [NB-1:0]    lane_en;
  logic [DW-1:0]    rd_word;
  logic             wr_en;

  logic [7:0] mem [MEM_BYTES] = '{default: INIT_VAL};

  logic unused_bits;
  assign unused_bits = ^{hburst, hprot, haddr[AW-1:MA]};

  assign accept = hsel && hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);

  // Alignment is judged on the raw bus address; the window on the wrapped offset.
  assign size_mask = (7'd1 << hsize) - 7'd1;
  assign misalign  = |(haddr[6:0] & size_mask);
  assign oversize  = 32'(hsize) > 32'(LB);
  assign off32     = 32'(haddr[MA-1:0]);
  assign in_win    = (ERR_SIZE != 0) && (off32 >= ERR_BASE) && (off32 < ERR_BASE + ERR_SIZE);
  assign err_now   = misalign || oversize || in_win || err_inj;

  always_comb begin
    if (hwrite) wait_len = (htrans == HTRANS_SEQ) ? 4'(LW_S) : 4'(LW_NS);
    else        wait_len = (htrans == HTRANS_SEQ) ? 4'(LR_S) : 4'(LR_NS);
  end

  ahb_lite_resp_fsm u_fsm (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .accept    (accept),
    .err       (err_now),
    .wait_len  (wait_len),
    .take      (take),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .dp_done   (dp_done)
  );

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dp_addr  <= '0;
      dp_write <= 1'b0;
      dp_size  <= '0;
      dp_err   <= 1'b0;
    end else if (take) begin
      dp_addr  <= haddr[MA-1:0];
      dp_write <= hwrite;
      dp_size  <= hsize;
      dp_err   <= err_now;
    end
  end

  // Lane i carries byte offset i (little) or NB-1-i (big, byte-invariant).
  assign mask_le = lane_mask(dp_addr[2:0], dp_size, int'(DW));

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NB; i++) begin
      lane_off[i]  = (BIG_ENDIAN != 0) ? 3'(NB - 1 - i) : 3'(i);
      lane_addr[i] = {dp_addr[MA-1:LB], lane_off[i][LB-1:0]};
      lane_en[i]   = mask_le[lane_off[i]];
      if (lane_en[i]) rd_word[8*i +: 8] = mem[lane_addr[i]];
    end
  end

  assign wr_en  = dp_done && dp_write && !dp_err;
  assign hrdata = (dp_done && !dp_write) ? rd_word : '0;

  always_ff @(posedge hclk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (lane_en[i]) mem[lane_addr[i]] <= hwdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench: two slaves (little-endian zero-wait, big-endian with read waits) on one bus.
module tb_ahb_lite_sram_slave;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        bus_sel = 1'b0;
  bit          tgt = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'd0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2;
  logic [2:0]  hburst = 3'd0;
  logic [3:0]  hprot = 4'd0;
  logic [31:0] hwdata = '0;
  logic        err_inj = 1'b0;

  logic        hsel0, hsel1, hready;
  logic        ro0, ro1, resp0, resp1;
  logic [31:0] hrdata0, hrdata1;
  logic        sel_ro, sel_resp;
  logic [31:0] sel_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] r_data;
  int          r_wait;
  logic        r_resp1, r_resp2;
  bit          r_nz;

  always #5 hclk = ~hclk;

  assign hsel0     = bus_sel & ~tgt;
  assign hsel1     = bus_sel & tgt;
  assign hready    = ro0 & ro1;
  assign sel_ro    = tgt ? ro1 : ro0;
  assign sel_resp  = tgt ? resp1 : resp0;
  assign sel_rdata = tgt ? hrdata1 : hrdata0;

  ahb_lite_sram_slave #(.BIG_ENDIAN(0), .LR_NS(0), .ERR_SIZE(16)) u0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hready(hready), .hreadyout(ro0), .hresp(resp0), .hrdata(hrdata0), .err_inj(err_inj));

  ahb_lite_sram_slave #(.BIG_ENDIAN(1), .LR_NS(2), .LR_S(0)) u1 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hready(hready), .hreadyout(ro1), .hresp(resp1), .hrdata(hrdata1), .err_inj(err_inj));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after a posedge; returns #1 after the posedge that ends the data phase.
  task automatic xfer(input bit t, input bit wr, input logic [31:0] addr,
                      input logic [2:0] size, input logic [1:0] trans,
                      input logic [31:0] wdata, input bit inj);
    bit done;
    tgt = t; bus_sel = 1'b1; haddr = addr; hwrite = wr; hsize = size;
    htrans = trans; err_inj = inj;
    @(posedge hclk); #1;
    bus_sel = 1'b0; htrans = 2'd0; err_inj = 1'b0; hwdata = wdata;
    r_wait = 0; r_resp1 = 1'b0; r_resp2 = 1'b0; r_nz = 1'b0; r_data = '0; done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (sel_ro) begin
        r_data = sel_rdata; r_resp2 = sel_resp; done = 1'b1;
        break;
      end
      if (r_wait == 0) r_resp1 = sel_resp;
      if (sel_rdata != 0) r_nz = 1'b1;
      r_wait++;
      @(posedge hclk); #1;
    end
    if (!done) chk("timeout_hreadyout", 32'(sel_ro), 32'd1);
    @(posedge hclk); #1;
  endtask

  initial begin
    repeat (2) @(posedge hclk);
    #1;
    chk("rst_ro0", 32'(ro0), 32'd1);
    chk("rst_resp0", 32'(resp0), 32'd0);
    chk("rst_rdata0", hrdata0, 32'd0);
    chk("rst_ro1", 32'(ro1), 32'd1);
    @(negedge hclk); hresetn = 1'b1;
    @(posedge hclk); #1;

    // zero-wait write then read on the little-endian slave
    xfer(0, 1, 32'h10, 3'd2, 2'd2, 32'hDEADBEEF, 0);
    chk("zw_wr_wait", 32'(r_wait), 32'd0);
    chk("zw_wr_resp", 32'(r_resp2), 32'd0);
    xfer(0, 0, 32'h10, 3'd2, 2'd2, 32'h0, 0);
    chk("zw_rd_wait", 32'(r_wait), 32'd0);
    chk("zw_rd_data", r_data, 32'hDEADBEEF);

    // wait states on the big-endian slave: NONSEQ read 2 waits, SEQ read none
    xfer(1, 1, 32'h10, 3'd2, 2'd2, 32'hDEADBEEF, 0);
    chk("be_wr_wait", 32'(r_wait), 32'd0);
    xfer(1, 0, 32'h10, 3'd2, 2'd2, 32'h0, 0);
    chk("ws_ns_wait", 32'(r_wait), 32'd2);
    chk("ws_ns_resp1", 32'(r_resp1), 32'd0);
    chk("ws_ns_rd_zero_in_wait", 32'(r_nz), 32'd0);
    chk("ws_ns_data", r_data, 32'hDEADBEEF);
    xfer(1, 0, 32'h14, 3'd2, 2'd3, 32'h0, 0);
    chk("ws_seq_wait", 32'(r_wait), 32'd0);
    chk("ws_seq_data", r_data, 32'h0);

    // byte writes: lane 3 little-endian, lane 0 big-endian
    xfer(0, 1, 32'h13, 3'd0, 2'd2, 32'hA5000000, 0);
    xfer(0, 0, 32'h10, 3'd2, 2'd2, 32'h0, 0);
    chk("le_byte_word", r_data, 32'hA5ADBEEF);
    xfer(0, 0, 32'h12, 3'd0, 2'd2, 32'h0, 0);
    chk("le_byte_read_lane", r_data, 32'h00AD0000);
    xfer(1, 1, 32'h13, 3'd0, 2'd2, 32'h000000A5, 0);
    xfer(1, 0, 32'h10, 3'd2, 2'd2, 32'h0, 0);
    chk("be_byte_word", r_data, 32'hDEADBEA5);

    // misaligned word and oversize: two-cycle ERROR, no write
    xfer(0, 1, 32'h12, 3'd2, 2'd2, 32'h11111111, 0);
    chk("mis_wait", 32'(r_wait), 32'd1);
    chk("mis_resp1", 32'(r_resp1), 32'd1);
    chk("mis_resp2", 32'(r_resp2), 32'd1);
    xfer(0, 1, 32'h10, 3'd3, 2'd2, 32'h22222222, 0);
    chk("oversize_resp2", 32'(r_resp2), 32'd1);
    xfer(0, 0, 32'h10, 3'd2, 2'd2, 32'h0, 0);
    chk("mis_after_resp", 32'(r_resp2), 32'd0);
    chk("mis_after_data", r_data, 32'hA5ADBEEF);

    // error window [0xF00,0xF10) on u0, disabled on u1
    xfer(0, 0, 32'hF04, 3'd2, 2'd2, 32'h0, 0);
    chk("win_in_wait", 32'(r_wait), 32'd1);
    chk("win_in_resp", 32'(r_resp2), 32'd1);
    xfer(0, 0, 32'hF0C, 3'd2, 2'd2, 32'h0, 0);
    chk("win_last_resp", 32'(r_resp2), 32'd1);
    xfer(0, 0, 32'hF10, 3'd2, 2'd2, 32'h0, 0);
    chk("win_above_resp", 32'(r_resp2), 32'd0);
    xfer(0, 0, 32'hEFC, 3'd2, 2'd2, 32'h0, 0);
    chk("win_below_resp", 32'(r_resp2), 32'd0);
    xfer(1, 0, 32'hF04, 3'd2, 2'd2, 32'h0, 0);
    chk("win_off_resp", 32'(r_resp2), 32'd0);

    // injected error suppresses the write
    xfer(0, 1, 32'h18, 3'd2, 2'd2, 32'h12345678, 1);
    chk("inj_resp", 32'(r_resp2), 32'd1);
    xfer(0, 0, 32'h18, 3'd2, 2'd2, 32'h0, 0);
    chk("inj_no_write", r_data, 32'h0);

    // address wraps modulo MEM_BYTES
    xfer(0, 1, 32'h1004, 3'd2, 2'd2, 32'hCAFEF00D, 0);
    xfer(0, 0, 32'h4, 3'd2, 2'd2, 32'h0, 0);
    chk("wrap_data", r_data, 32'hCAFEF00D);

    // pipelined write then read of the same address
    tgt = 0; bus_sel = 1'b1; haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2; htrans = 2'd2;
    @(posedge hclk); #1;
    hwdata = 32'h0BADF00D; hwrite = 1'b0;
    chk("b2b_wr_ready", 32'(ro0), 32'd1);
    @(posedge hclk); #1;
    bus_sel = 1'b0; htrans = 2'd0;
    chk("b2b_rd_ready", 32'(ro0), 32'd1);
    chk("b2b_rd_data", hrdata0, 32'h0BADF00D);
    @(posedge hclk); #1;

    // reset during WAIT on u1
    tgt = 1; bus_sel = 1'b1; haddr = 32'h10; hwrite = 1'b0; hsize = 3'd2; htrans = 2'd2;
    @(posedge hclk); #1;
    bus_sel = 1'b0; htrans = 2'd0;
    chk("rst_pre_wait_ro", 32'(ro1), 32'd0);
    hresetn = 1'b0;
    #1;
    chk("rst_mid_ro", 32'(ro1), 32'd1);
    chk("rst_mid_resp", 32'(resp1), 32'd0);
    chk("rst_mid_rdata", hrdata1, 32'd0);
    @(negedge hclk); hresetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge hclk); #1;
      chk("post_rst_idle_ro", 32'(ro1), 32'd1);
      chk("post_rst_idle_rdata", hrdata1, 32'd0);
    end
    xfer(1, 0, 32'h10, 3'd2, 2'd2, 32'h0, 0);
    chk("post_rst_wait", 32'(r_wait), 32'd2);
    chk("post_rst_retained_u1", r_data, 32'hDEADBEA5);
    xfer(0, 0, 32'h4, 3'd2, 2'd2, 32'h0, 0);
    chk("post_rst_retained_u0", r_data, 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
Next-generation AHB-Lite slave memory model for VIP/DUT benches: byte-addressable SRAM with parametrised data width, depth, endianness and per-type wait states. It adds protocol checking (misalignment, oversize, error window, injected error) with a compliant two-cycle ERROR response, and proper HREADY (input) / HREADYOUT separation for multi-slave AHB-Lite fabrics. It sits behind the address decoder as one slave on the AHB-Lite bus.

Parameters:
AW, 32, address width
DW, 32, data width; 32 or 64
MEM_BYTES, 4096, memory size in bytes; power of 2; address wraps modulo MEM_BYTES
BIG_ENDIAN, 0, 1 = byte address 0 maps to lane DW/8-1 (byte-invariant BE); 0 = lane 0
LW_NS / LW_S, 0 / 0, write wait states for NONSEQ / SEQ
LR_NS / LR_S, 1 / 0, read wait states for NONSEQ / SEQ; each 0..15
ERR_BASE, 'hF00, first byte offset of error window
ERR_SIZE, 0, error window length in bytes; 0 disables the window
INIT_VAL, 8'h00, power-on byte value of the memory

Ports:
hclk  in  1  bus clock
hresetn  in  1  asynchronous active-low reset
hsel  in  1  slave select from the decoder
haddr  in  AW  address
htrans  in  2  IDLE=0 BUSY=1 NONSEQ=2 SEQ=3
hwrite  in  1  1 = write
hsize  in  3  transfer size, log2 bytes
hburst  in  3  burst type; informational only
hprot  in  4  protection; ignored
hwdata  in  DW  write data (data phase)
hready  in  1  bus HREADY; an address phase is accepted only when high
hreadyout  out  1  slave ready
hresp  out  1  0 = OKAY, 1 = ERROR
hrdata  out  DW  read data
err_inj  in  1  force an ERROR response for the transfer in its address phase

Behaviour:
- Reset: hresetn is asynchronous, active-low; clock is hclk. While reset is asserted: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, pending transfer dropped. Memory contents are unaffected by reset; they are INIT_VAL only at time 0.
- Accept: a transfer is accepted when hsel & hready & htrans[1] at a posedge. The controller registers addr (masked to MEM_BYTES-1), write, size, the NONSEQ/SEQ flag and the error flag.
- IDLE/BUSY or unselected: no data phase; hreadyout=1, hresp=0.
- Error flag is set if any of: (haddr mod 2^hsize) != 0; hsize > log2(DW/8); addr in [ERR_BASE, ERR_BASE+ERR_SIZE); err_inj=1.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: on accept with error -> ERR1. On accept with L>0 -> WAIT, load counter with L. On accept with L=0 -> stay in IDLE; the data phase completes in the next cycle with hreadyout=1.
  - WAIT: hreadyout=0, hresp=0; counter decrements each cycle; at 1 -> IDLE with hreadyout=1 in the following cycle.
  - ERR1: hreadyout=0, hresp=1 -> ERR2.
  - ERR2: hreadyout=1, hresp=1 -> IDLE. If a new accept occurs in ERR2, it is processed as from IDLE.
  - L is chosen from LW_*/LR_* by the registered write flag and NONSEQ/SEQ flag. Wait states are not applied to error transfers.
- Write: the byte lanes covered by [addr mod DW/8, +2^size) are written from hwdata at the posedge ending the data phase (hreadyout=1). No write occurs on error.
- Read: hrdata carries the addressed lanes, other lanes 0, during the final data-phase cycle only; otherwise hrdata=0. It is read combinationally from the array, so back-to-back write-then-read of the same address returns the new data.
- Pipelining: a new address phase may be accepted in the same cycle the current data phase completes.
- Counter width: 4 bits.

Decomposition:
- Package ahb_lite_pkg: htrans/hsize/hresp enums and constants, and a function for byte-lane mask (addr, size, DW).
- Sub-module ahb_lite_resp_fsm: contains the FSM and wait counter, outputs hreadyout, hresp and a data-phase-done strobe.
- The top level holds the address-phase registers, the memory array and the lane logic.

Test Plan:
- Zero-wait write then read: NONSEQ write word 0x10 = 0xDEADBEEF, then NONSEQ read 0x10 -> hreadyout never low; hrdata=0xDEADBEEF in the read data phase.
- Wait states: LR_NS=2; read -> hreadyout 0,0,1 across the data phase. Then a SEQ read with LR_S=0 -> single cycle.
- Byte write with BIG_ENDIAN=0: write byte 0x13 = 0xA5 (hsize=0, data on lane 3) -> a word read of 0x10 returns 0xA5ADBEEF. Repeat with BIG_ENDIAN=1 -> lane 0 written.
- Misaligned access: word access to 0x12 -> hresp 1/hreadyout 0, then hresp 1/hreadyout 1; memory unchanged; the next transfer completes OKAY.
- Error window and injection: ERR_SIZE=16, read at 0xF04 -> two-cycle ERROR. Assert err_inj on a valid write -> ERROR and no write. Address MEM_BYTES+4 -> wraps to offset 4.
- Reset mid-transfer: assert hresetn low during WAIT -> hreadyout=1, hresp=0 immediately; after release an IDLE bus produces no response; memory retains prior data.
